sr_reg: RTL and testbench

- Architectural status register (R2) storage stage, directly downstream of the SR flag-merge mux.
- Captures `reg_SR_in` on flag updates, direct R2 writes, interrupt entry and RETI restore.
- Feeds `reg_SR_out` back to the mux and to the register-file read path.
- Owns the low-power halt/wake sequencing and the delayed-GIE (EINT) effect.

---
 rtl/sr_reg_if.sv | 29 ++
 rtl/sr_reg.sv | 120 ++++++++++++
 tb/tb_sr_reg.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sr_reg_if.sv
// Status-register stage bus: core-side strobes into sr_reg and the SR/halt outputs back.
interface sr_reg_if;
    logic [15:0] reg_SR_in;
    logic        sr_flag_we;
    logic [15:0] sr_wr_data;
    logic        sr_wr_en;
    logic [15:0] reti_data;
    logic        reti_en;
    logic        irq_entry;
    logic        instr_done;
    logic        irq_pending;
    logic        nmi_pending;
    logic [15:0] reg_SR_out;
    logic        gie_eff;
    logic        cpu_halt;
    logic        wake_pulse;

    modport master (
        output reg_SR_in, sr_flag_we, sr_wr_data, sr_wr_en, reti_data, reti_en,
               irq_entry, instr_done, irq_pending, nmi_pending,
        input  reg_SR_out, gie_eff, cpu_halt, wake_pulse
    );

    modport slave (
        input  reg_SR_in, sr_flag_we, sr_wr_data, sr_wr_en, reti_data, reti_en,
               irq_entry, instr_done, irq_pending, nmi_pending,
        output reg_SR_out, gie_eff, cpu_halt, wake_pulse
    );
endinterface

// File: rtl/sr_reg.sv
// Architectural SR (R2) storage with delayed-GIE and halt/wake sequencing.
// Optional macro SR_RESERVED_MASK_EN forces SR[15:9] to zero on every write source.
module sr_reg #(
    parameter int unsigned GIE_DELAY   = 1,
    parameter int unsigned WAKE_CYCLES = 1
) (
    input logic     clk,
    input logic     rst,
    sr_reg_if.slave bus
);
    localparam int unsigned GieIdx    = 3;
    localparam int unsigned CpuoffIdx = 4;

`ifdef SR_RESERVED_MASK_EN
    localparam logic [15:0] WrMask = 16'h01FF;
`else
    localparam logic [15:0] WrMask = 16'hFFFF;
`endif

    typedef enum logic [1:0] {StRun, StHaltPend, StHalt, StWake} state_e;

    state_e      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [1:0]  gie_cnt_q, gie_cnt_d;
    logic [2:0]  wake_cnt_q, wake_cnt_d;
    logic        wake_pulse_q, wake_pulse_d;
    logic        sw_write;
    logic        gie_eff;
    logic        wake_req;

    assign gie_eff  = sr_q[GieIdx] && (gie_cnt_q == 2'd0);
    assign wake_req = bus.nmi_pending || (bus.irq_pending && gie_eff);

    always_comb begin
        sr_d     = sr_q;
        sw_write = 1'b0;
        if (bus.irq_entry) begin
            sr_d = sr_q & 16'h0040;
        end else if (bus.reti_en) begin
            sr_d = bus.reti_data & WrMask;
        end else if (bus.sr_wr_en) begin
            sr_d     = bus.sr_wr_data & WrMask;
            sw_write = 1'b1;
        end else if (bus.sr_flag_we) begin
            sr_d     = bus.reg_SR_in & WrMask;
            sw_write = 1'b1;
        end
    end

    // Only software writes arm the delay; a load shadows a coincident instr_done.
    always_comb begin
        gie_cnt_d = gie_cnt_q;
        if (bus.irq_entry || bus.reti_en || (sw_write && !sr_d[GieIdx])) begin
            gie_cnt_d = 2'd0;
        end else if (sw_write && !sr_q[GieIdx]) begin
            gie_cnt_d = 2'(GIE_DELAY);
        end else if (bus.instr_done && (gie_cnt_q != 2'd0)) begin
            gie_cnt_d = gie_cnt_q - 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        wake_cnt_d   = wake_cnt_q;
        wake_pulse_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (sr_d[CpuoffIdx] && !sr_q[CpuoffIdx]) begin
                    state_d = StHaltPend;
                end
            end
            StHaltPend: begin
                if (!sr_d[CpuoffIdx]) begin
                    state_d = StRun;
                end else if (bus.instr_done) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                // Wake beats a same-cycle CPUOFF clear so the pulse is never lost.
                if (wake_req) begin
                    state_d      = StWake;
                    wake_cnt_d   = 3'd0;
                    wake_pulse_d = 1'b1;
                end else if (!sr_d[CpuoffIdx]) begin
                    state_d = StRun;
                end
            end
            StWake: begin
                if (wake_cnt_q >= 3'(WAKE_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    wake_cnt_d = wake_cnt_q + 3'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            sr_q         <= 16'h0000;
            gie_cnt_q    <= 2'd0;
            wake_cnt_q   <= 3'd0;
            wake_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            gie_cnt_q    <= gie_cnt_d;
            wake_cnt_q   <= wake_cnt_d;
            wake_pulse_q <= wake_pulse_d;
        end
    end

    assign bus.reg_SR_out = sr_q;
    assign bus.gie_eff    = gie_eff;
    assign bus.cpu_halt   = (state_q == StHalt);
    assign bus.wake_pulse = wake_pulse_q;
endmodule

// File: tb/tb_sr_reg.sv
// Scoreboard bench for sr_reg: directed scenarios then random traffic against a behavioural model.
module tb_sr_reg;
    localparam int unsigned TbGieDelay   = 1;
    localparam int unsigned TbWakeCycles = 2;

    typedef struct packed {
        logic [15:0] sr;
        logic        eff;
        logic        halt;
        logic        pulse;
    } exp_t;

    logic clk;
    logic rst;
    sr_reg_if bus ();

    sr_reg #(
        .GIE_DELAY  (TbGieDelay),
        .WAKE_CYCLES(TbWakeCycles)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t sb_q[$];
    int   n_vec;
    int   n_bad;

    // Model state: SR value, remaining GIE delay, and the halt story as plain flags/counts.
    logic [15:0] m_sr;
    int          m_delay;
    bit          m_pend;
    bit          m_halted;
    int          m_wake_left;
    bit          m_pulse;

    task automatic model_step();
        logic [15:0] old_sr, new_sr;
        bit          eff_now, sw, wake;
        if (rst) begin
            m_sr = 16'h0000; m_delay = 0; m_pend = 0; m_halted = 0;
            m_wake_left = 0; m_pulse = 0;
            return;
        end
        old_sr  = m_sr;
        eff_now = old_sr[3] && (m_delay == 0);
        sw      = 0;
        if (bus.irq_entry)       new_sr = {9'b0, old_sr[6], 6'b0};
        else if (bus.reti_en)    new_sr = bus.reti_data;
        else if (bus.sr_wr_en)   begin new_sr = bus.sr_wr_data; sw = 1; end
        else if (bus.sr_flag_we) begin new_sr = bus.reg_SR_in;  sw = 1; end
        else                     new_sr = old_sr;
`ifdef SR_RESERVED_MASK_EN
        if (!bus.irq_entry) new_sr[15:9] = 7'd0;
`endif
        if (bus.irq_entry || bus.reti_en || (sw && !new_sr[3])) m_delay = 0;
        else if (sw && !old_sr[3])                             m_delay = TbGieDelay;
        else if (bus.instr_done && m_delay > 0)                m_delay--;

        wake    = bus.nmi_pending || (bus.irq_pending && eff_now);
        m_pulse = 0;
        if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_halted) begin
            if (wake) begin
                m_halted = 0; m_wake_left = TbWakeCycles; m_pulse = 1;
            end else if (!new_sr[4]) begin
                m_halted = 0;
            end
        end else if (m_pend) begin
            if (!new_sr[4]) m_pend = 0;
            else if (bus.instr_done) begin m_pend = 0; m_halted = 1; end
        end else if (new_sr[4] && !old_sr[4]) begin
            m_pend = 1;
        end
        m_sr = new_sr;
    endtask

    task automatic idle();
        bus.reg_SR_in  = 16'h0000; bus.sr_flag_we  = 1'b0;
        bus.sr_wr_data = 16'h0000; bus.sr_wr_en    = 1'b0;
        bus.reti_data  = 16'h0000; bus.reti_en     = 1'b0;
        bus.irq_entry  = 1'b0;     bus.instr_done  = 1'b0;
        bus.irq_pending = 1'b0;    bus.nmi_pending = 1'b0;
        rst = 1'b0;
    endtask

    // Called at a falling edge with inputs set: predict the post-edge outputs, then advance.
    task automatic tick();
        exp_t e;
        model_step();
        e.sr    = m_sr;
        e.eff   = m_sr[3] && (m_delay == 0);
        e.halt  = m_halted;
        e.pulse = m_pulse;
        sb_q.push_back(e);
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input logic [15:0] d);
        bus.sr_wr_en = 1'b1; bus.sr_wr_data = d; tick();
    endtask

    initial begin : monitor
        exp_t        e;
        logic [15:0] act_sr, cmp_mask;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e        = sb_q.pop_front();
                act_sr   = bus.reg_SR_out;
                cmp_mask = 16'hFFFF;
`ifndef SR_RESERVED_MASK_EN
                if ($isunknown(act_sr[15:9])) cmp_mask = 16'h01FF;
`endif
                n_vec++;
                if (((act_sr & cmp_mask) !== (e.sr & cmp_mask)) || (bus.gie_eff !== e.eff) ||
                    (bus.cpu_halt !== e.halt) || (bus.wake_pulse !== e.pulse)) begin
                    n_bad++;
                    $display("FAIL vec%0d t=%0t sr/eff/halt/pulse got %h/%b/%b/%b want %h/%b/%b/%b",
                             n_vec, $time, act_sr, bus.gie_eff, bus.cpu_halt, bus.wake_pulse,
                             e.sr, e.eff, e.halt, e.pulse);
                end
            end
        end
    end

    initial begin : stim
        n_vec = 0;
        n_bad = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b1; tick();
        rst = 1'b1; tick();

        bus.sr_flag_we = 1'b1; bus.reg_SR_in = 16'h0107; tick();
        tick();
        wr(16'h0008); tick(); tick();
        bus.instr_done = 1'b1; tick();
        tick();
        wr(16'h0000); tick();

        wr(16'h0048);
        bus.irq_entry = 1'b1; tick();
        bus.reti_en = 1'b1; bus.reti_data = 16'h0008; tick();
        tick();

        wr(16'h0018); tick();
        bus.instr_done = 1'b1; tick();
        tick(); tick();
        bus.irq_pending = 1'b1; tick();
        for (int i = 0; i < 4; i++) tick();

        wr(16'h0010);
        bus.instr_done = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin bus.irq_pending = 1'b1; tick(); end
        bus.nmi_pending = 1'b1; tick();
        for (int i = 0; i < 4; i++) tick();

        wr(16'h0010);
        bus.instr_done = 1'b1; tick();
        rst = 1'b1; tick();
        tick();

        bus.sr_wr_en = 1'b1; bus.sr_wr_data = 16'hFE01; bus.irq_entry = 1'b1; tick();
        wr(16'hFE01); tick();

        for (int i = 0; i < 4000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d[4] = 1'b1;
            bus.sr_wr_en    = ($urandom_range(0, 7) == 0);
            bus.sr_wr_data  = d;
            bus.sr_flag_we  = ($urandom_range(0, 3) == 0);
            bus.reg_SR_in   = 16'($urandom);
            bus.reti_en     = ($urandom_range(0, 15) == 0);
            bus.reti_data   = 16'($urandom);
            bus.irq_entry   = ($urandom_range(0, 19) == 0);
            bus.instr_done  = ($urandom_range(0, 2) == 0);
            bus.irq_pending = ($urandom_range(0, 3) == 0);
            bus.nmi_pending = ($urandom_range(0, 29) == 0);
            rst             = ($urandom_range(0, 499) == 0);
            tick();
        end

        repeat (4) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left, 0 required", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
